// File: rtl/booth_wallace_mul_pipe_pkg.sv
// Shared definitions for the pipelined Booth/Wallace multiplier.
// Contents:
//   - Booth radix-4 digit codes, packed as {neg, x2, x1}, and the recoder.
//   - Elaboration-time helpers that size the pipeline from the operand width:
//     the partial-product row count, the 3:2 tree depth and the total latency.
package mul_pkg;

  // Recoded digit = (neg ? -1 : +1) * (x2 ? 2 : x1 ? 1 : 0) times the multiplicand.
  localparam logic [2:0] BOOTH_ZERO = 3'b000;
  localparam logic [2:0] BOOTH_P1   = 3'b001;
  localparam logic [2:0] BOOTH_P2   = 3'b010;
  localparam logic [2:0] BOOTH_M1   = 3'b101;
  localparam logic [2:0] BOOTH_M2   = 3'b110;

  // The window is {b[2i+1], b[2i], b[2i-1]}; its digit value is -2*w[2] + w[1] + w[0].
  function automatic logic [2:0] booth_encode(input logic [2:0] win);
    case (win)
      3'b000, 3'b111: booth_encode = BOOTH_ZERO;
      3'b001, 3'b010: booth_encode = BOOTH_P1;
      3'b011:         booth_encode = BOOTH_P2;
      3'b100:         booth_encode = BOOTH_M2;
      3'b101, 3'b110: booth_encode = BOOTH_M1;
      default:        booth_encode = BOOTH_ZERO;
    endcase
  endfunction

  // The multiplier is widened by two bits (sign or zero), so it always has
  // WIDTH/2+1 radix-4 digits.
  function automatic int booth_rows(input int width);
    return (width / 2) + 1;
  endfunction

  // Rows left after one 3:2 level: every full group of three becomes two
  // rows, and the leftover rows pass straight through.
  function automatic int csa_next(input int n);
    return (2 * (n / 3)) + (n % 3);
  endfunction

  // Row count entering tree level lvl (level 0 sees the raw partial products).
  function automatic int csa_rows_at(input int n, input int lvl);
    int rows;
    rows = n;
    for (int i = 0; i < lvl; i++) begin
      rows = csa_next(rows);
    end
    return rows;
  endfunction

  // Minimum number of 3:2 levels needed to reach two rows.
  function automatic int csa_levels(input int n);
    int rows;
    int lvl;
    rows = n;
    lvl  = 0;
    for (int i = 0; i < 64; i++) begin
      if (rows > 2) begin
        rows = csa_next(rows);
        lvl  = lvl + 1;
      end
    end
    return lvl;
  endfunction

  // Register stages: input capture, partial products, one per tree level,
  // and the final adder.
  function automatic int pipe_lat(input int width);
    return csa_levels(booth_rows(width)) + 3;
  endfunction

endpackage

// File: rtl/booth_wallace_mul_pipe_if.sv
// Operation/result bus of the pipelined multiplier.
//   flush              : kill every operation in flight at the next edge
//   in_valid/in_ready  : operation handshake; a, b, a_signed, b_signed, in_tag
//   out_valid/out_ready: result handshake; product, out_tag
//   busy               : any operation in flight or a result waiting
// master = the client that issues operations; slave = the multiplier.
interface booth_wallace_mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               a_signed;
  logic               b_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  modport master (
    output flush, in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
    input  in_ready, out_valid, product, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
    output in_ready, out_valid, product, out_tag, busy
  );
endinterface

// File: rtl/booth_wallace_mul_pipe_csa.sv
// 3:2 carry-save adder row.
//   i_x, i_y, i_z : three addend rows
//   o_sum         : bitwise sum
//   o_carry       : majority carries, already shifted up by one bit
// o_sum + o_carry == i_x + i_y + i_z (mod 2^WIDTH).
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);
  assign o_sum   = i_x ^ i_y ^ i_z;
  // Carry out of the top bit falls off the row width.
  assign o_carry = {(i_x[WIDTH-2:0] & i_y[WIDTH-2:0]) |
                    (i_x[WIDTH-2:0] & i_z[WIDTH-2:0]) |
                    (i_y[WIDTH-2:0] & i_z[WIDTH-2:0]), 1'b0};
endmodule

// File: rtl/booth_wallace_mul_pipe_pp.sv
// Radix-4 Booth recoder and partial-product generator (combinational).
//   i_a, i_a_signed : multiplicand and its signedness
//   i_b, i_b_signed : multiplier and its signedness
//   o_pp            : WIDTH/2+1 partial products, each a full 2*WIDTH-bit
//                     two's-complement row already shifted into place
// Every row is sign-extended to the full product width, so plain modular
// addition of all rows yields the exact product.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic               i_a_signed,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_b_signed,
  output logic [2*WIDTH-1:0] o_pp [booth_rows(WIDTH)]
);
  localparam int N  = booth_rows(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    w_a_ext;
  logic [WIDTH+2:0] w_b_win;
  logic [2:0]       w_code [N];
  logic [PW-1:0]    w_mag  [N];

  // Recode the multiplier and form each shifted, signed partial product.
  always_comb begin
    w_a_ext = {{WIDTH{i_a_signed & i_a[WIDTH-1]}}, i_a};
    // Two extension bits on top, the implicit b[-1]=0 at the bottom.
    w_b_win = {{2{i_b_signed & i_b[WIDTH-1]}}, i_b, 1'b0};
    for (int i = 0; i < N; i++) begin
      w_code[i] = booth_encode(w_b_win[2*i+2 -: 3]);
      if (w_code[i][1]) begin
        w_mag[i] = {w_a_ext[PW-2:0], 1'b0};
      end else if (w_code[i][0]) begin
        w_mag[i] = w_a_ext;
      end else begin
        w_mag[i] = {PW{1'b0}};
      end
      if (w_code[i][2]) begin
        o_pp[i] = (~w_mag[i] + {{(PW-1){1'b0}}, 1'b1}) << (2 * i);
      end else begin
        o_pp[i] = w_mag[i] << (2 * i);
      end
    end
  end
endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier: radix-4 Booth partial
// products, a registered 3:2 Wallace tree and a final carry-propagate adder.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears valids, product, out_tag)
//   bus   : operation/result bus (slave side), see booth_wallace_mul_pipe_if
// The whole pipe advances as one unit: when the result slot is occupied and
// not drained, every stage holds. A tag and valid bit ride with each stage.
module booth_wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_wallace_mul_pipe_if.slave bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int N   = booth_rows(WIDTH);
  localparam int L   = csa_levels(N);
  localparam int LAT = pipe_lat(WIDTH);

  logic             w_adv;
  logic [LAT-1:0]   r_vld;
  logic [TAG_W-1:0] r_tag [LAT];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_signed;
  logic             r_b_signed;
  logic [PW-1:0]    w_pp    [N];
  logic [PW-1:0]    r_rows  [0:L][N];
  logic [PW-1:0]    w_nxt   [1:L][N];
  logic [PW-1:0]    r_product;

  // The pipe moves whenever the output slot is empty or being consumed.
  assign w_adv = !r_vld[LAT-1] || bus.out_ready;

  // Valid and tag shift register; flush wins over accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= {LAT{1'b0}};
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= {TAG_W{1'b0}};
      end
    end else if (bus.flush) begin
      r_vld <= {LAT{1'b0}};
    end else if (w_adv) begin
      r_vld    <= {r_vld[LAT-2:0], bus.in_valid};
      r_tag[0] <= bus.in_tag;
      for (int s = 1; s < LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Operand capture; contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a        <= bus.a;
      r_b        <= bus.b;
      r_a_signed <= bus.a_signed;
      r_b_signed <= bus.b_signed;
    end
  end

  booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
    .i_a        (r_a),
    .i_a_signed (r_a_signed),
    .i_b        (r_b),
    .i_b_signed (r_b_signed),
    .o_pp       (w_pp)
  );

  // Tree wiring: level lv reduces r_rows[lv] into w_nxt[lv+1]. Rows beyond
  // the live count of a level are tied to zero and never read.
  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int NI = csa_rows_at(N, lv);
    localparam int NG = NI / 3;
    localparam int NR = NI % 3;

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_3to2 #(.WIDTH(PW)) u_csa (
        .i_x     (r_rows[lv][3*g]),
        .i_y     (r_rows[lv][3*g+1]),
        .i_z     (r_rows[lv][3*g+2]),
        .o_sum   (w_nxt[lv+1][2*g]),
        .o_carry (w_nxt[lv+1][2*g+1])
      );
    end

    for (genvar p = 0; p < NR; p++) begin : g_pass
      assign w_nxt[lv+1][2*NG+p] = r_rows[lv][3*NG+p];
    end

    for (genvar z = 2*NG+NR; z < N; z++) begin : g_zero
      assign w_nxt[lv+1][z] = {PW{1'b0}};
    end
  end

  // Partial-product and tree-level registers.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_rows[0] <= w_pp;
      for (int lv = 1; lv <= L; lv++) begin
        r_rows[lv] <= w_nxt[lv];
      end
    end
  end

  // Final carry-propagate adder into the visible product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= {PW{1'b0}};
    end else if (w_adv) begin
      r_product <= r_rows[L][0] + r_rows[L][1];
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[LAT-1];
  assign bus.product   = r_product;
  assign bus.out_tag   = r_tag[LAT-1];
  assign bus.busy      = |r_vld;
endmodule

// File: doc/booth_wallace_mul_pipe.md
BOOTH_WALLACE_MUL_PIPE -- requirements
Module: booth_wallace_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; even, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each operation.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous kill of all in-flight operations.
REQ-006 SHALL have port in_valid  input  1  an operation is offered.
REQ-007 SHALL have port in_ready  output  1  the operation is accepted this cycle.
REQ-008 SHALL have port a  input  WIDTH  multiplicand.
REQ-009 SHALL have port b  input  WIDTH  multiplier.
REQ-010 SHALL have port a_signed  input  1  a is two's complement when 1, unsigned when 0.
REQ-011 SHALL have port b_signed  input  1  b is two's complement when 1, unsigned when 0.
REQ-012 SHALL have port in_tag  input  TAG_W  opaque tag.
REQ-013 SHALL have port out_valid  output  1  result is valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port product  output  2*WIDTH  full-width product.
REQ-016 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-017 SHALL have port busy  output  1  any valid operation is in flight, or out_valid is high.

Function
REQ-018 SHALL compute product = a*b exactly in 2*WIDTH bits, with each operand sign-extended or zero-extended per its *_signed bit (covers MUL/MULH/MULHSU/MULHU).
REQ-019 SHALL use radix-4 Booth recoding of b, with b extended by one bit per b_signed, giving N = WIDTH/2+1 partial products.
REQ-020 SHALL reduce the partial products by a 3:2 CSA Wallace tree of L levels, where L is the minimum number of levels reducing N rows to 2 (WIDTH=32: L=6), followed by one carry-propagate adder.
REQ-021 SHALL register at these points: input capture, partial-product generation, each CSA level, and the final adder output, giving LAT = L+3 (WIDTH=32: LAT=9).
REQ-022 SHALL accept an operation at rising edge k when in_valid && in_ready, and present its result with out_valid=1 immediately after edge k+LAT-1 (LAT edges counting edge k as the first).
REQ-023 SHALL carry a per-stage valid bit and tag alongside the data; out_valid SHALL NOT be asserted for stages that carry no operation.
REQ-024 SHALL drive in_ready = !out_valid || out_ready; when in_ready=0, every pipeline register, including valid and tag, SHALL hold.
REQ-025 SHALL keep product and out_tag stable while out_valid && !out_ready.
REQ-026 SHALL sustain one operation per cycle throughput when out_ready is held at 1, with no bubbles inserted.
REQ-027 SHALL clear all valid bits at the next edge when flush=1, regardless of in_ready; an input offered in the same cycle as flush is dropped; flush has priority over accept.
REQ-028 SHALL treat data registers of invalid stages as don't-care, with only valid bits gating outputs.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear all valid bits, with out_valid=0 and busy=0; in_ready SHALL read 1 after reset.
REQ-030 SHALL reset product and out_tag to 0.
REQ-031 SHALL discard all in-flight operations on reset asserted mid-operation, with no result emitted after reset release.
REQ-032 SHALL require data/tag pipeline registers to be reset only where the reset costs no timing.

Structure
REQ-033 SHALL place the following in shared package mul_pkg: the function computing L from N, the LAT derivation, and the Booth digit encoding constants.
REQ-034 SHALL instantiate the 3:2 carry-save adder as sub-module csa_3to2, parametrised by width, once per tree node.
REQ-035 SHALL place Booth recoding and partial-product generation in combinational sub-module booth_pp_gen, parametrised by WIDTH.

Verification
REQ-036 SHALL cover, at WIDTH=32 with signed×signed and out_ready=1: a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x0000000000000001, out_valid exactly 9 cycles after accept.
REQ-037 SHALL cover unsigned×unsigned a=b=0xFFFFFFFF -> 0xFFFFFFFE00000001; signed a=b=0x80000000 -> 0x4000000000000000.
REQ-038 SHALL cover a_signed=1, b_signed=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF00000001.
REQ-039 SHALL cover 16 back-to-back operations with tags 0..15 and random operands -> 16 consecutive out_valid cycles, tags in order, all products matching the reference model.
REQ-040 SHALL cover out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, product/out_tag frozen, no result lost or duplicated after release.
REQ-041 SHALL cover flush, and rst_n pulsed low, each with 4 operations in flight -> no out_valid afterwards, busy=0 next cycle, and a new operation then completes correctly.
